// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared encodings for the hardwired control sequencer:
//             opcode values, ALU operation codes and the 4-bit state encoding.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  // Opcodes, taken from the top five bits of the instruction register
  localparam logic [4:0] C_OP_ADD  = 5'b00000;
  localparam logic [4:0] C_OP_SUB  = 5'b00001;
  localparam logic [4:0] C_OP_AND  = 5'b00010;
  localparam logic [4:0] C_OP_OR   = 5'b00011;
  localparam logic [4:0] C_OP_SHR  = 5'b00100;
  localparam logic [4:0] C_OP_SHL  = 5'b00101;
  localparam logic [4:0] C_OP_ADDI = 5'b01000;
  localparam logic [4:0] C_OP_ANDI = 5'b01001;
  localparam logic [4:0] C_OP_ORI  = 5'b01010;
  localparam logic [4:0] C_OP_NOP  = 5'b11000;
  localparam logic [4:0] C_OP_HALT = 5'b11001;

  // ALU operation codes presented on alu_op
  localparam logic [3:0] C_ALU_ADD = 4'd0;
  localparam logic [3:0] C_ALU_SUB = 4'd1;
  localparam logic [3:0] C_ALU_AND = 4'd2;
  localparam logic [3:0] C_ALU_OR  = 4'd3;
  localparam logic [3:0] C_ALU_SHR = 4'd4;
  localparam logic [3:0] C_ALU_SHL = 4'd5;

  // Sequencer states: fetch is T0..T2, execute is T3..T5
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Purpose  : Combinational opcode classifier for the control sequencer.
//  Ports    : i_opcode      in  5  opcode field of the IR
//             o_alu_op      out 4  ALU operation (ADD for non-ALU opcodes)
//             o_is_rtype    out 1  register/register ALU instruction
//             o_is_imm      out 1  register/immediate ALU instruction
//             o_is_nop      out 1  NOP
//             o_is_halt     out 1  HALT
//             o_is_illegal  out 1  any undefined opcode
//  Revision : 1.0  initial release
// ============================================================================
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [3:0] o_alu_op,
  output logic       o_is_rtype,
  output logic       o_is_imm,
  output logic       o_is_nop,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  always_comb begin
    o_alu_op     = C_ALU_ADD;
    o_is_rtype   = 1'b0;
    o_is_imm     = 1'b0;
    o_is_nop     = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      C_OP_ADD:  begin o_is_rtype = 1'b1; o_alu_op = C_ALU_ADD; end
      C_OP_SUB:  begin o_is_rtype = 1'b1; o_alu_op = C_ALU_SUB; end
      C_OP_AND:  begin o_is_rtype = 1'b1; o_alu_op = C_ALU_AND; end
      C_OP_OR:   begin o_is_rtype = 1'b1; o_alu_op = C_ALU_OR;  end
      C_OP_SHR:  begin o_is_rtype = 1'b1; o_alu_op = C_ALU_SHR; end
      C_OP_SHL:  begin o_is_rtype = 1'b1; o_alu_op = C_ALU_SHL; end
      C_OP_ADDI: begin o_is_imm   = 1'b1; o_alu_op = C_ALU_ADD; end
      C_OP_ANDI: begin o_is_imm   = 1'b1; o_alu_op = C_ALU_AND; end
      C_OP_ORI:  begin o_is_imm   = 1'b1; o_alu_op = C_ALU_OR;  end
      C_OP_NOP:  o_is_nop     = 1'b1;
      C_OP_HALT: o_is_halt    = 1'b1;
      default:   o_is_illegal = 1'b1;
    endcase
  end

endmodule : instr_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Hardwired fetch/execute sequencer driving datapath strobes.
//             Waits in T1 for mem_ready with a bounded timeout, halts on
//             HALT opcode, memory timeout, or stop at an instruction boundary.
//  Ports    : clock, clear (async, active-high)     in  1
//             ir                                    in  IR_W
//             mem_ready, stop                       in  1
//             PCout PCin IncPC MARin Zin Zlowout    out 1
//             Read MDRin MDRout IRin Yin            out 1
//             Gra Grb Grc Rin Rout Cout             out 1
//             alu_op                                out 4
//             run, illegal, mem_err                 out 1
//  Revision : 1.0  initial release
// ============================================================================
module control_unit
  import ctrl_pkg::*;
#(
  parameter int IR_W        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            Cout,
  output logic [3:0]      alu_op,
  output logic            run,
  output logic            illegal,
  output logic            mem_err
);

  localparam logic [3:0] C_TIMEOUT = 4'(MEM_TIMEOUT);

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic       r_mem_err;

  logic [3:0] w_alu_op;
  logic       w_is_rtype;
  logic       w_is_imm;
  logic       w_is_nop;
  logic       w_is_halt;
  logic       w_is_illegal;
  logic [3:0] w_cnt_nxt;
  logic       w_unused_ir;

  // Only the opcode field steers the sequencer; the rest of the IR is datapath-only.
  assign w_unused_ir = ^ir[IR_W-6:0];

  instr_decode u_decode (
    .i_opcode     (ir[IR_W-1 -: 5]),
    .o_alu_op     (w_alu_op),
    .o_is_rtype   (w_is_rtype),
    .o_is_imm     (w_is_imm),
    .o_is_nop     (w_is_nop),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  assign w_cnt_nxt = r_wait_cnt + 4'd1;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state    <= S_RST;
      r_wait_cnt <= 4'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        S_RST: r_state <= S_T0;
        S_T0:  r_state <= S_T1;
        S_T1: begin
          // mem_ready is tested first so data arriving on the final wait cycle still wins
          if (mem_ready) begin
            r_state    <= S_T2;
            r_wait_cnt <= 4'd0;
          end else if (w_cnt_nxt == C_TIMEOUT) begin
            r_state    <= S_HALT;
            r_mem_err  <= 1'b1;
            r_wait_cnt <= 4'd0;
          end else begin
            r_wait_cnt <= w_cnt_nxt;
          end
        end
        S_T2: r_state <= S_T3;
        S_T3: begin
          if (w_is_halt)
            r_state <= S_HALT;
          else if (w_is_nop || w_is_illegal)
            r_state <= stop ? S_HALT : S_T0;
          else
            r_state <= S_T4;
        end
        S_T4:   r_state <= S_T5;
        S_T5:   r_state <= stop ? S_HALT : S_T0;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

  // Moore decode: state register plus opcode class during execute
  always_comb begin
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    Cout    = 1'b0;
    alu_op  = C_ALU_ADD;
    run     = 1'b0;
    illegal = 1'b0;
    case (r_state)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run     = 1'b1;
        illegal = w_is_illegal;
        if (w_is_rtype || w_is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        run    = 1'b1;
        Zin    = 1'b1;
        alu_op = w_alu_op;
        if (w_is_rtype) begin
          Grc = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
      end
      S_T5: begin
        run = 1'b1; Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_err = r_mem_err;

endmodule : control_unit
`default_nettype wire
